mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache (I-side refill) and the data cache (D-side refill/write).
- Accepts level requests from each cache and arbitrates them round-robin.
- Sequences one memory transaction at a time and returns the 128-bit line to the granted cache with a one-cycle done pulse.
- Sits between I_Cache/D-cache and Main_Memory.

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  // D-cache side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  // Main memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       i_grant_cnt,
  output logic [15:0]       d_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_DONE_I = 3'd3;
  localparam logic [2:0] S_DONE_D = 3'd4;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [2:0]        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              i_done_q,     i_done_d;
  logic              d_done_q,     d_done_d;
  logic [LINE_W-1:0] i_rdata_q,    i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q,    d_rdata_d;

  logic              grant_i;
  logic              grant_d;

  // On a conflict the side that was not served last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == S_IDLE) begin
      grant_i = i_req && (!d_req || (last_grant_q == GRANT_D));
      grant_d = d_req && (!i_req || (last_grant_q == GRANT_I));
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_i) begin
          state_d      = S_BUSY_I;
          last_grant_d = GRANT_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_addr;
        end else if (grant_d) begin
          state_d      = S_BUSY_D;
          last_grant_d = GRANT_D;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end
      end

      S_BUSY_I: begin
        if (mem_ready) begin
          state_d   = S_DONE_I;
          mem_req_d = 1'b0;
          i_rdata_d = mem_rdata;
          i_done_d  = 1'b1;
        end
      end

      S_BUSY_D: begin
        if (mem_ready) begin
          state_d   = S_DONE_D;
          mem_req_d = 1'b0;
          d_rdata_d = mem_rdata;
          d_done_d  = 1'b1;
        end
      end

      // The done cycle gives the requester time to drop req before re-arbitration.
      S_DONE_I,
      S_DONE_D: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_D;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] i_grant_cnt_q,  i_grant_cnt_d;
  logic [15:0] d_grant_cnt_q,  d_grant_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_comb begin
    i_grant_cnt_d  = i_grant_cnt_q;
    d_grant_cnt_d  = d_grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant_i && (i_grant_cnt_q != 16'hFFFF)) begin
      i_grant_cnt_d = i_grant_cnt_q + 16'd1;
    end
    if (grant_d && (d_grant_cnt_q != 16'hFFFF)) begin
      d_grant_cnt_d = d_grant_cnt_q + 16'd1;
    end
    if ((state_q == S_IDLE) && i_req && d_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      i_grant_cnt_q  <= i_grant_cnt_d;
      d_grant_cnt_q  <= d_grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single-side transactions,
// round-robin alternation, stray mem_ready, and asynchronous reset mid-transaction.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  localparam logic [LINE_W-1:0] LINE_A = 128'hDEAD_0001_0203_0405_0607_0809_0A0B_BEEF;
  localparam logic [LINE_W-1:0] LINE_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LINE_W-1:0] LINE_C = 128'hA5A5_5A5A_F0F0_0F0F_1234_5678_9ABC_DEF0;
  localparam logic [LINE_W-1:0] LINE_D = 128'h0BAD_CAFE_0000_FFFF_C0DE_D00D_8BAD_F00D;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]       i_grant_cnt;
  logic [15:0]       d_grant_cnt;
  logic [15:0]       conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .WORD_W(WORD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] exp_addr;
  logic              exp_is_i;

  initial begin
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();

    // Reset state
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_done",    i_done,    0);
    check("rst_d_done",    d_done,    0);
    check("rst_i_rdata",   i_rdata,   0);
    check("rst_d_rdata",   d_rdata,   0);
    rst = 1'b0;
    tick();

    // I-side read, memory answers one cycle after mem_req rises
    i_req  = 1'b1;
    i_addr = 32'h0000_0400;
    tick();
    check("i1_mem_req",  mem_req,  1);
    check("i1_mem_addr", mem_addr, 32'h0000_0400);
    check("i1_mem_we",   mem_we,   0);
    check("i1_done_early", i_done, 0);
    tick();
    check("i1_done_wait", i_done, 0);
    mem_ready = 1'b1;
    mem_rdata = LINE_A;
    tick();
    check("i1_done",    i_done,  1);
    check("i1_rdata",   i_rdata, LINE_A);
    check("i1_req_off", mem_req, 0);
    check("i1_d_done",  d_done,  0);
    i_req     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    check("i1_done_once", i_done,  0);
    check("i1_rdata_hold", i_rdata, LINE_A);
    tick();

    // D-side write, memory answers after four cycles
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h1000_0010;
    d_wdata = 32'hCAFE_F00D;
    tick();
    d_wdata = 32'h0;
    d_addr  = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      check("d2_mem_req",   mem_req,   1);
      check("d2_mem_we",    mem_we,    1);
      check("d2_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("d2_mem_addr",  mem_addr,  32'h1000_0010);
      check("d2_i_done",    i_done,    0);
      if (c == 3) begin
        mem_ready = 1'b1;
        mem_rdata = LINE_B;
      end
      tick();
    end
    check("d2_done",    d_done,  1);
    check("d2_i_done_end", i_done, 0);
    check("d2_req_off", mem_req, 0);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("d2_done_once", d_done, 0);
    tick();

    // Stray mem_ready while idle
    mem_ready = 1'b1;
    mem_rdata = LINE_C;
    tick();
    mem_ready = 1'b0;
    check("idle_mem_req", mem_req, 0);
    check("idle_i_done",  i_done,  0);
    check("idle_d_done",  d_done,  0);
    check("idle_i_rdata", i_rdata, LINE_A);
    check("idle_d_rdata", d_rdata, LINE_B);
    tick();
    check("idle_mem_req2", mem_req, 0);
    check("idle_i_done2",  i_done,  0);

    // Reset asserted while a D read is in flight
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h2000_0040;
    tick();
    check("rb_mem_req",  mem_req,  1);
    check("rb_mem_addr", mem_addr, 32'h2000_0040);
    #2;
    rst = 1'b1;
    #1;
    check("rb_async_req",  mem_req,  0);
    check("rb_async_addr", mem_addr, 0);
    check("rb_d_rdata",    d_rdata,  0);
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    mem_ready = 1'b0;
    check("rb_no_done", d_done,  0);
    check("rb_held",    mem_req, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rb_regrant_req",  mem_req,  1);
    check("rb_regrant_addr", mem_addr, 32'h2000_0040);
    check("rb_regrant_we",   mem_we,   0);
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    check("rb_done",  d_done,  1);
    check("rb_rdata", d_rdata, LINE_D);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    tick();

    // Both requesters held continuously after reset: grants alternate I, D, ...
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    i_addr = 32'h0000_1230;
    d_addr = 32'h4000_0080;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_is_i = (t % 2 == 0);
      exp_addr = exp_is_i ? 32'h0000_1230 : 32'h4000_0080;
      tick();
      check("rr_mem_req",  mem_req,  1);
      check("rr_mem_addr", mem_addr, exp_addr);
      mem_ready = 1'b1;
      mem_rdata = exp_is_i ? LINE_A : LINE_C;
      tick();
      mem_ready = 1'b0;
      check("rr_i_done", i_done, exp_is_i);
      check("rr_d_done", d_done, !exp_is_i);
      tick();
    end
    check("rr_i_rdata", i_rdata, LINE_A);
    check("rr_d_rdata", d_rdata, LINE_C);
`ifdef MEM_ARB_PERF_EN
    check("perf_i_grants", i_grant_cnt, 3);
    check("perf_d_grants", d_grant_cnt, 3);
    check("perf_conflict_min", conflict_cnt >= 16'd3, 1);
`endif
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    check("end_mem_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
